// File: rtl/rtl_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rtl_skid_pipe
// Description : Cascade of STAGES full-throughput valid/ready skid buffers.
//               Each stage has one main register, which is the stage output,
//               and one skid register that catches a word arriving while the
//               main register is stalled. Every signal leaving the block
//               (up_ready, down_valid, down_data) comes straight from a flop.
//               Optional build macro RTL_SKID_CLEAR_EN: data registers reset
//               to zero and down_data reads zero while down_valid is low.
// Revision    : 1.0 - initial release
// ============================================================================
module rtl_skid_pipe #(
    parameter int D_WIDTH = 6,
    parameter int STAGES  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready
);

    localparam int c_bus_w = (STAGES + 1) * D_WIDTH;

    // Inter-stage handshake buses. Index k is the input side of stage k;
    // index STAGES is the block output side.
    logic [STAGES:0]    w_vld;
    logic [STAGES:0]    w_rdy;
    logic [c_bus_w-1:0] w_dat;

    assign w_vld[0]           = up_valid;
    assign w_dat[D_WIDTH-1:0] = up_data;
    assign up_ready           = w_rdy[0];

    assign w_rdy[STAGES]      = down_ready;
    assign down_valid         = w_vld[STAGES];

`ifdef RTL_SKID_CLEAR_EN
    // Present zero on the payload whenever nothing is offered downstream.
    assign down_data = w_vld[STAGES] ? w_dat[STAGES*D_WIDTH +: D_WIDTH]
                                     : {D_WIDTH{1'b0}};
`else
    assign down_data = w_dat[STAGES*D_WIDTH +: D_WIDTH];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage

        logic               r_main_valid;
        logic [D_WIDTH-1:0] r_main_data;
        logic               r_skid_valid;
        logic [D_WIDTH-1:0] r_skid_data;

        logic               w_in_valid;
        logic [D_WIDTH-1:0] w_in_data;
        logic               w_out_ready;
        logic               w_accept;
        logic               w_main_free;
        logic               w_main_from_skid;
        logic               w_main_from_in;
        logic               w_skid_load;

        assign w_in_valid  = w_vld[k];
        assign w_in_data   = w_dat[k*D_WIDTH +: D_WIDTH];
        assign w_out_ready = w_rdy[k+1];

        // Ready toward the producer is simply "skid is empty", a flop output.
        assign w_accept    = w_in_valid & ~r_skid_valid;

        // Main register can take a new word when it is empty or being read.
        assign w_main_free = ~r_main_valid | w_out_ready;

        // A full skid always has priority for the main register; while the
        // skid is full w_accept is low, so no incoming word competes.
        assign w_main_from_skid = w_main_free & r_skid_valid;
        assign w_main_from_in   = w_main_free & ~r_skid_valid & w_accept;

        // Skid only fills when a word arrives while main is stalled.
        assign w_skid_load      = ~w_main_free & w_accept;

        // Valid flags: cleared asynchronously, advanced on each handshake.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else begin
                if (w_main_free) begin
                    if (r_skid_valid) begin
                        r_main_valid <= 1'b1;
                        r_skid_valid <= 1'b0;
                    end else begin
                        r_main_valid <= w_accept;
                    end
                end else if (w_accept) begin
                    r_skid_valid <= 1'b1;
                end
            end
        end

`ifdef RTL_SKID_CLEAR_EN
        // Payload registers, zeroed by reset, written only when loaded.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_main_data <= {D_WIDTH{1'b0}};
                r_skid_data <= {D_WIDTH{1'b0}};
            end else begin
                if (w_main_from_skid) begin
                    r_main_data <= r_skid_data;
                end else if (w_main_from_in) begin
                    r_main_data <= w_in_data;
                end
                if (w_skid_load) begin
                    r_skid_data <= w_in_data;
                end
            end
        end
`else
        // Payload registers carry no reset and are written only when loaded.
        always_ff @(posedge clk) begin
            if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
            end else if (w_main_from_in) begin
                r_main_data <= w_in_data;
            end
            if (w_skid_load) begin
                r_skid_data <= w_in_data;
            end
        end
`endif

        assign w_rdy[k]                         = ~r_skid_valid;
        assign w_vld[k+1]                       = r_main_valid;
        assign w_dat[(k+1)*D_WIDTH +: D_WIDTH]  = r_main_data;

    end : g_stage

endmodule : rtl_skid_pipe
`default_nettype wire

// File: tb/tb_rtl_skid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtl_skid_pipe
// Description : Self-checking bench. Instance A (one stage) is compared every
//               cycle against an exact queue model; instance B (three stages)
//               is checked for ordering, stability under stall and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtl_skid_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] a_up_data   = '0;
    logic       a_up_valid  = 1'b0;
    logic       a_up_ready;
    logic [5:0] a_down_data;
    logic       a_down_valid;
    logic       a_down_ready = 1'b0;

    logic [5:0] b_up_data   = '0;
    logic       b_up_valid  = 1'b0;
    logic       b_up_ready;
    logic [5:0] b_down_data;
    logic       b_down_valid;
    logic       b_down_ready = 1'b0;

    rtl_skid_pipe #(.D_WIDTH(6), .STAGES(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .up_data    (a_up_data),
        .up_valid   (a_up_valid),
        .up_ready   (a_up_ready),
        .down_data  (a_down_data),
        .down_valid (a_down_valid),
        .down_ready (a_down_ready)
    );

    rtl_skid_pipe #(.D_WIDTH(6), .STAGES(3)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .up_data    (b_up_data),
        .up_valid   (b_up_valid),
        .up_ready   (b_up_ready),
        .down_data  (b_down_data),
        .down_valid (b_down_valid),
        .down_ready (b_down_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference state: words inside each instance, in arrival order.
    logic [5:0] qa[$];
    logic [5:0] qb[$];
    int         b_rx = 0;

    // Per-cycle comparison and model update, away from the active edge.
    initial begin
        int         n;
        logic       acc;
        logic       pop;
        logic       b_prev_stall;
        logic [5:0] b_prev_data;
        b_prev_stall = 1'b0;
        b_prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                qa.delete();
                qb.delete();
                b_prev_stall = 1'b0;
            end else begin
                // Single stage: ready while fewer than two words held.
                n = qa.size();
                check("a_up_ready", int'(a_up_ready), int'(n < 2));
                check("a_down_valid", int'(a_down_valid), int'(n > 0));
                if (n > 0)
                    check("a_down_data", int'(a_down_data), int'(qa[0]));
`ifdef RTL_SKID_CLEAR_EN
                else
                    check("a_down_data_zero", int'(a_down_data), 0);
`endif
                acc = a_up_valid && (n < 2);
                pop = (n > 0) && a_down_ready;
                if (pop) void'(qa.pop_front());
                if (acc) qa.push_back(a_up_data);

                // Three stages: order, stability, occupancy.
                if (b_down_valid) begin
                    if (qb.size() == 0)
                        check("b_spurious_word", 1, 0);
                    else
                        check("b_down_data", int'(b_down_data), int'(qb[0]));
                end
                if (b_prev_stall) begin
                    check("b_stall_valid", int'(b_down_valid), 1);
                    check("b_stall_data", int'(b_down_data), int'(b_prev_data));
                end
                if (qb.size() < 2)
                    check("b_up_ready_low_occ", int'(b_up_ready), 1);
                if (b_down_valid && b_down_ready && qb.size() > 0) begin
                    void'(qb.pop_front());
                    b_rx++;
                end
                if (b_up_valid && b_up_ready) qb.push_back(b_up_data);
                check("b_occupancy_le_6", int'(qb.size() <= 6), 1);
                b_prev_stall = b_down_valid && !b_down_ready;
                b_prev_data  = b_down_data;
            end
        end
    end

    task automatic idle_a(input int cycles);
        a_up_valid   = 1'b0;
        a_down_ready = 1'b1;
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        logic [5:0] words [1000];
        int         sent;
        int         cyc;
        int         base;
        logic       acc;

        // Reset state, before any clock edge has been seen.
        #1;
        check("rst_a_down_valid", int'(a_down_valid), 0);
        check("rst_a_up_ready", int'(a_up_ready), 1);
        check("rst_b_down_valid", int'(b_down_valid), 0);
        check("rst_b_up_ready", int'(b_up_ready), 1);
        step();
        step();
        rst = 1'b0;
        idle_a(2);

        // Streaming 0x01..0x3F: one-cycle latency, one word per cycle.
        a_down_ready = 1'b1;
        for (int i = 1; i < 64; i++) begin
            check("stream_up_ready", int'(a_up_ready), 1);
            a_up_data  = 6'(i);
            a_up_valid = 1'b1;
            step();
            check("stream_valid", int'(a_down_valid), 1);
            check("stream_data", int'(a_down_data), i);
        end
        idle_a(3);

        // Single-cycle stall: one word parks in the skid, no bubble after.
        for (int i = 0; i < 3; i++) begin
            a_up_data  = 6'(8'h20 + i);
            a_up_valid = 1'b1;
            step();
        end
        a_up_data    = 6'h23;
        a_down_ready = 1'b0;
        step();
        check("stall_up_ready", int'(a_up_ready), 0);
        check("stall_data_held", int'(a_down_data), 8'h22);
        a_up_data    = 6'h24;
        a_down_ready = 1'b1;
        step();
        check("stall_skid_drain", int'(a_down_data), 8'h23);
        check("stall_ready_back", int'(a_up_ready), 1);
        step();
        check("stall_no_bubble_v", int'(a_down_valid), 1);
        check("stall_no_bubble_d", int'(a_down_data), 8'h24);
        a_up_data = 6'h25;
        step();
        check("stall_next", int'(a_down_data), 8'h25);
        idle_a(3);

        // Backpressure: 0x0A, 0x0B taken, 0x0C held until space.
        a_down_ready = 1'b0;
        a_up_valid   = 1'b1;
        a_up_data    = 6'h0A;
        step();
        a_up_data    = 6'h0B;
        check("bp_ready_second", int'(a_up_ready), 1);
        step();
        a_up_data    = 6'h0C;
        check("bp_ready_full", int'(a_up_ready), 0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data", int'(a_down_data), 8'h0A);
            check("bp_hold_ready", int'(a_up_ready), 0);
            step();
        end
        a_down_ready = 1'b1;
        step();
        check("bp_out_0b", int'(a_down_data), 8'h0B);
        check("bp_ready_again", int'(a_up_ready), 1);
        step();
        check("bp_out_0c", int'(a_down_data), 8'h0C);
        check("bp_out_0c_v", int'(a_down_valid), 1);
        a_up_valid = 1'b0;
        step();
        check("bp_empty", int'(a_down_valid), 0);
        idle_a(2);

        // Simultaneous accept and emit with main full, skid empty.
        a_down_ready = 1'b0;
        a_up_valid   = 1'b1;
        a_up_data    = 6'h15;
        step();
        a_up_data    = 6'h2A;
        a_down_ready = 1'b1;
        step();
        check("simul_data", int'(a_down_data), 8'h2A);
        check("simul_valid", int'(a_down_valid), 1);
        check("simul_skid_empty", int'(a_up_ready), 1);
        a_up_valid = 1'b0;
        step();
        check("simul_drained", int'(a_down_valid), 0);
        idle_a(2);

        // Asynchronous reset with two words buffered.
        a_down_ready = 1'b0;
        a_up_valid   = 1'b1;
        a_up_data    = 6'h11;
        step();
        a_up_data    = 6'h12;
        step();
        a_up_valid   = 1'b0;
        check("pre_rst_full", int'(a_up_ready), 0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(a_down_valid), 0);
        check("async_rst_ready", int'(a_up_ready), 1);
`ifdef RTL_SKID_CLEAR_EN
        check("async_rst_data", int'(a_down_data), 0);
`endif
        @(posedge clk);
        #1;
        rst          = 1'b0;
        a_down_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("post_rst_no_words", int'(a_down_valid), 0);
        a_up_valid = 1'b1;
        a_up_data  = 6'h21;
        step();
        check("post_rst_first_v", int'(a_down_valid), 1);
        check("post_rst_first_d", int'(a_down_data), 8'h21);
        idle_a(2);

        // Three-stage latency.
        b_down_ready = 1'b1;
        b_up_valid   = 1'b1;
        b_up_data    = 6'h33;
        step();
        b_up_valid = 1'b0;
        check("b_lat_c1", int'(b_down_valid), 0);
        step();
        check("b_lat_c2", int'(b_down_valid), 0);
        step();
        check("b_lat_c3_v", int'(b_down_valid), 1);
        check("b_lat_c3_d", int'(b_down_data), 8'h33);
        step();
        check("b_lat_gone", int'(b_down_valid), 0);

        // Random traffic, 50% valid and 50% ready, 1000 words.
        for (int i = 0; i < 1000; i++) words[i] = 6'($urandom_range(0, 63));
        base = b_rx;
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            b_up_valid   = 1'($urandom_range(0, 1));
            b_up_data    = words[sent];
            b_down_ready = 1'($urandom_range(0, 1));
            acc          = b_up_valid && b_up_ready;
            step();
            if (acc) sent++;
            cyc++;
        end
        check("b_all_sent", sent, 1000);
        b_up_valid   = 1'b0;
        b_down_ready = 1'b1;
        cyc = 0;
        while (qb.size() > 0 && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        check("b_drained", qb.size(), 0);
        check("b_received", b_rx - base, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rtl_skid_pipe
`default_nettype wire
